// File: rtl/instr_encoder.sv
// RV32I instruction encoder: decoded fields + signed immediate -> packed word.
// Two-stage valid/ready pipeline (check, pack) with a running byte address tag.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_count
);

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_B  = 3'd3,
    FMT_U  = 3'd4,
    FMT_J  = 3'd5,
    FMT_X6 = 3'd6,
    FMT_X7 = 3'd7
  } fmt_e;

  localparam logic [ADDR_W-1:0] ADDR_RST = ADDR_W'(BASE_ADDR);

  // stage 1 state
  logic        s1_valid_q, s1_valid_d;
  fmt_e        s1_fmt_q, s1_fmt_d;
  logic [6:0]  s1_opc_q, s1_opc_d;
  logic [2:0]  s1_f3_q, s1_f3_d;
  logic [6:0]  s1_f7_q, s1_f7_d;
  logic [4:0]  s1_rd_q, s1_rd_d;
  logic [4:0]  s1_rs1_q, s1_rs1_d;
  logic [4:0]  s1_rs2_q, s1_rs2_d;
  logic [31:0] s1_imm_q, s1_imm_d;
  logic        s1_legal_q, s1_legal_d;

  // stage 2 / output state
  logic              s2_valid_q, s2_valid_d;
  logic [31:0]       instr_q, instr_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        cnt_q, cnt_d;

  logic        s2_load;
  logic        in_fire;
  logic        out_fire;
  logic        legal;
  logic [31:0] pack_word;
  logic signed [31:0] imm_s;

  assign imm_s    = $signed(imm);
  assign s2_load  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_load;
  assign in_fire  = in_valid && in_ready && !restart;
  assign out_fire = s2_valid_q && out_ready && !restart;

  always_comb begin
    legal = 1'b0;
    case (fmt_e'(fmt))
      FMT_R: legal = 1'b1;
      FMT_I, FMT_S:
        legal = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
      FMT_B:
        legal = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094)
                && !imm[0];
      FMT_J:
        legal = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574)
                && !imm[0];
      FMT_U: legal = (imm[11:0] == 12'h000);
      default: legal = 1'b0;
    endcase
  end

  // Illegal words fall through to NOP_WORD.
  always_comb begin
    pack_word = NOP_WORD;
    if (s1_legal_q) begin
      case (s1_fmt_q)
        FMT_R: pack_word = {s1_f7_q, s1_rs2_q, s1_rs1_q,
                            s1_f3_q, s1_rd_q, s1_opc_q};
        FMT_I: pack_word = {s1_imm_q[11:0], s1_rs1_q,
                            s1_f3_q, s1_rd_q, s1_opc_q};
        FMT_S: pack_word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q,
                            s1_f3_q, s1_imm_q[4:0], s1_opc_q};
        FMT_B: pack_word = {s1_imm_q[12], s1_imm_q[10:5],
                            s1_rs2_q, s1_rs1_q, s1_f3_q,
                            s1_imm_q[4:1], s1_imm_q[11], s1_opc_q};
        FMT_U: pack_word = {s1_imm_q[31:12], s1_rd_q, s1_opc_q};
        FMT_J: pack_word = {s1_imm_q[20], s1_imm_q[10:1],
                            s1_imm_q[11], s1_imm_q[19:12],
                            s1_rd_q, s1_opc_q};
        default: pack_word = NOP_WORD;
      endcase
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_fmt_d   = s1_fmt_q;
    s1_opc_d   = s1_opc_q;
    s1_f3_d    = s1_f3_q;
    s1_f7_d    = s1_f7_q;
    s1_rd_d    = s1_rd_q;
    s1_rs1_d   = s1_rs1_q;
    s1_rs2_d   = s1_rs2_q;
    s1_imm_d   = s1_imm_q;
    s1_legal_d = s1_legal_q;
    s2_valid_d = s2_valid_q;
    instr_d    = instr_q;
    err_d      = err_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;

    if (restart) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      addr_d     = ADDR_RST;
    end else begin
      if (s2_load) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          instr_d = pack_word;
          err_d   = !s1_legal_q;
        end
      end
      if (in_ready) begin
        s1_valid_d = in_valid;
      end
      if (in_fire) begin
        s1_fmt_d   = fmt_e'(fmt);
        s1_opc_d   = opcode;
        s1_f3_d    = funct3;
        s1_f7_d    = funct7;
        s1_rd_d    = rd;
        s1_rs1_d   = rs1;
        s1_rs2_d   = rs2;
        s1_imm_d   = imm;
        s1_legal_d = legal;
      end
      if (out_fire) begin
        addr_d = addr_q + ADDR_W'(4);
        if (err_q && cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_fmt_q   <= FMT_R;
      s1_opc_q   <= '0;
      s1_f3_q    <= '0;
      s1_f7_q    <= '0;
      s1_rd_q    <= '0;
      s1_rs1_q   <= '0;
      s1_rs2_q   <= '0;
      s1_imm_q   <= '0;
      s1_legal_q <= 1'b0;
      s2_valid_q <= 1'b0;
      instr_q    <= '0;
      err_q      <= 1'b0;
      addr_q     <= ADDR_RST;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_fmt_q   <= s1_fmt_d;
      s1_opc_q   <= s1_opc_d;
      s1_f3_q    <= s1_f3_d;
      s1_f7_q    <= s1_f7_d;
      s1_rd_q    <= s1_rd_d;
      s1_rs1_q   <= s1_rs1_d;
      s1_rs2_q   <= s1_rs2_d;
      s1_imm_q   <= s1_imm_d;
      s1_legal_q <= s1_legal_d;
      s2_valid_q <= s2_valid_d;
      instr_q    <= instr_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_instr = instr_q;
  assign out_err   = err_q;
  assign out_addr  = addr_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: driver queues expected words,
// negedge monitor compares every presented word and tracks the address.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        restart;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_addr = 32'h0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  // monitor: held words must match the queue head and the address model
  always @(negedge clk) begin
    if (rst || restart) begin
      exp_addr = 32'h0;
    end else if (out_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL extra_word got instr=%h addr=%h", out_instr, out_addr);
      end else begin
        if (out_instr !== q[0].instr || out_err !== q[0].err ||
            out_addr !== exp_addr) begin
          errors++;
          $display("FAIL word got %h/%0b/%h expected %h/%0b/%h",
                   out_instr, out_err, out_addr,
                   q[0].instr, q[0].err, exp_addr);
        end
        if (out_ready) begin
          void'(q.pop_front());
          exp_addr = exp_addr + 32'd4;
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] opc,
                      input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im,
                      input logic [31:0] ew, input logic ee);
    bit ok = 0;
    fmt = f; opcode = opc; funct3 = f3; funct7 = f7;
    rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back('{instr: ew, err: ee});
        ok = 1;
      end
      cyc();
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready=0 expected 1");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) cyc();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending expected 0", q.size());
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    fmt = '0; opcode = '0; funct3 = '0; funct7 = '0;
    rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();

    // ADDI x1,x0,-1 with latency check
    send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0,
         32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
    @(negedge clk);
    chk("lat_cycle1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_cycle2", {31'd0, out_valid}, 32'd1);
    cyc();
    drain();

    // SW / BEQ from a fresh address
    do_restart();
    send(3'd2, 7'b0100011, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2,
         32'd8, 32'h0020_A423, 1'b0);
    send(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0,
         32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
    drain();

    // JAL, LUI, ADD
    send(3'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0,
         32'd2048, 32'h0010_00EF, 1'b0);
    send(3'd4, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0,
         32'h1234_5000, 32'h1234_52B7, 1'b0);
    send(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2,
         32'hDEAD_BEEF, 32'h0020_81B3, 1'b0);
    drain();

    // illegal immediates
    send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0,
         32'd2048, 32'h0000_0013, 1'b1);
    send(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0,
         32'd3, 32'h0000_0013, 1'b1);
    send(3'd4, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0,
         32'h1234_5001, 32'h0000_0013, 1'b1);
    drain();
    cyc();
    chk("err_count_3", {24'd0, err_count}, 32'd3);

    // range boundaries and illegal fmt
    send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0,
         32'd2047, 32'h7FF0_0013, 1'b0);
    send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0,
         32'hFFFF_F800, 32'h8000_0013, 1'b0);
    send(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0,
         32'd4094, 32'h7E00_0FE3, 1'b0);
    send(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0,
         32'd4096, 32'h0000_0013, 1'b1);
    send(3'd6, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0,
         32'd0, 32'h0000_0013, 1'b1);
    drain();
    cyc();
    chk("err_count_5", {24'd0, err_count}, 32'd5);

    // backpressure: 5 words, out_ready pattern 1,0,0
    do_restart();
    out_ready = 1'b0;
    send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0,
         32'd1, 32'h0010_0093, 1'b0);
    send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0,
         32'd2, 32'h0020_0113, 1'b0);
    @(negedge clk);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_out_addr", out_addr, 32'd0);
    cyc();
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          out_ready = (i % 3 == 0);
          cyc();
        end
        out_ready = 1'b1;
      end
      begin
        send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0,
             32'd3, 32'h0030_0193, 1'b0);
        send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0,
             32'd4, 32'h0040_0213, 1'b0);
        send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0,
             32'd5, 32'h0050_0293, 1'b0);
      end
    join
    drain();
    cyc();
    chk("bp_final_addr", out_addr, 32'd20);

    // restart with two words in flight
    out_ready = 1'b0;
    send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd6, 5'd0, 5'd0,
         32'd6, 32'h0060_0313, 1'b0);
    send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0,
         32'd7, 32'h0070_0393, 1'b0);
    out_ready = 1'b1;
    do_restart();
    @(negedge clk);
    chk("rs_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rs_out_addr", out_addr, 32'd0);
    chk("rs_err_kept", {24'd0, err_count}, 32'd5);
    cyc();
    send(3'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0,
         32'd2048, 32'h0010_00EF, 1'b0);
    drain();

    // async reset while stalled
    out_ready = 1'b0;
    send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0,
         32'd9999, 32'h0000_0013, 1'b1);
    send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0,
         32'd1, 32'h0010_0093, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_err_count", {24'd0, err_count}, 32'd0);
    chk("arst_out_addr", out_addr, 32'd0);
    q.delete();
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    send(3'd4, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0,
         32'h1234_5000, 32'h1234_52B7, 1'b0);
    drain();
    cyc();
    chk("post_rst_err", {24'd0, err_count}, 32'd0);
    chk("post_rst_addr", out_addr, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
